pulse_edge_buffer: RTL and testbench

//  Receiving end of the silencer output stream: captures one frame of DEPTH (intensity, phase)

---
 rtl/pulse_edge_buffer_pkg.sv | 14 +
 rtl/pulse_edge_calc.sv | 51 +++++
 rtl/pulse_edge_buffer.sv | 108 ++++++++++
 tb/tb_pulse_edge_buffer.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/pulse_edge_buffer_pkg.sv
// rtl/pulse_edge_buffer_pkg.sv - PWM period constants and edge-pair types shared with the PWM generators
package pulse_edge_buffer_pkg;

    localparam int PwmPeriodBits = 9;
    localparam int PwmPeriod     = 512;

    typedef logic [PwmPeriodBits-1:0] edge_t;

    typedef struct packed {
        edge_t rise;
        edge_t fall;
    } edge_pair_t;

endpackage

// File: rtl/pulse_edge_calc.sv
// rtl/pulse_edge_calc.sv - registers one beat as width/centre and derives its rise/fall edges
module pulse_edge_calc
    import pulse_edge_buffer_pkg::*;
#(
    parameter int AW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          valid_i,
    input  logic [AW-1:0] idx_i,
    input  logic [15:0]   intensity_i,
    input  logic [7:0]    phase_i,
    output logic          valid_o,
    output logic [AW-1:0] idx_o,
    output edge_pair_t    edges_o
);

    logic          valid_q;
    logic [AW-1:0] idx_q;
    edge_t         w_q;
    edge_t         c_q;
    edge_t         rise;
    logic          unused_intensity_lsbs;

    // Only the top byte of intensity sets the pulse width; 65025 maps to 254.
    assign unused_intensity_lsbs = ^intensity_i[7:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            idx_q   <= '0;
            w_q     <= '0;
            c_q     <= '0;
        end else begin
            valid_q <= valid_i;
            if (valid_i) begin
                idx_q <= idx_i;
                w_q   <= {1'b0, intensity_i[15:8]};
                c_q   <= {phase_i, 1'b0};
            end
        end
    end

    // Natural 9-bit wraparound gives the modulo-512 period arithmetic.
    assign rise         = c_q - (w_q >> 1);
    assign edges_o.rise = rise;
    assign edges_o.fall = rise + w_q;
    assign valid_o      = valid_q;
    assign idx_o        = idx_q;

endmodule

// File: rtl/pulse_edge_buffer.sv
// rtl/pulse_edge_buffer.sv - captures a frame of edge pairs into a double buffer swapped on PWM boundaries
module pulse_edge_buffer
    import pulse_edge_buffer_pkg::*;
#(
    parameter  int DEPTH = 249,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic                     CLK,
    input  logic                     RST_N,
    input  logic                     UPDATE,
    input  logic                     DIN_VALID,
    input  logic [15:0]              INTENSITY_IN,
    input  logic [7:0]               PHASE_IN,
    input  logic [AW-1:0]            RD_ADDR,
    output logic [PwmPeriodBits-1:0] RISE_OUT,
    output logic [PwmPeriodBits-1:0] FALL_OUT,
    output logic                     FRAME_VALID,
    output logic                     COMMIT,
    output logic                     OVERRUN
);

    localparam logic [AW-1:0] LastIdx = AW'(DEPTH - 1);

    logic [AW-1:0] idx_q, idx_d;
    logic          sel_q, sel_d;
    logic          pending_q, pending_d;
    logic          frame_valid_q, frame_valid_d;
    logic          commit_q;
    logic          overrun_q, overrun_d;
    edge_pair_t    edges_q, edges_d;

    logic          wr_en;
    logic [AW-1:0] wr_idx;
    edge_pair_t    wr_data;
    logic [AW:0]   wr_addr;
    logic [AW:0]   rd_addr;
    logic          last_wr;
    logic          swap;

    edge_pair_t    mem_q [2**(AW+1)];

    pulse_edge_calc #(.AW(AW)) u_calc (
        .clk         (CLK),
        .rst_n       (RST_N),
        .valid_i     (DIN_VALID),
        .idx_i       (idx_q),
        .intensity_i (INTENSITY_IN),
        .phase_i     (PHASE_IN),
        .valid_o     (wr_en),
        .idx_o       (wr_idx),
        .edges_o     (wr_data)
    );

    // Front bank is sel_q; writes always target the other bank.
    assign wr_addr = {~sel_q, wr_idx};
    assign last_wr = wr_en && (wr_idx == LastIdx);
    assign swap    = UPDATE && (pending_q || last_wr);
    assign rd_addr = {sel_d, RD_ADDR};

    always_comb begin
        idx_d         = idx_q;
        if (DIN_VALID) begin
            idx_d = (idx_q == LastIdx) ? '0 : idx_q + 1'b1;
        end
        sel_d         = sel_q ^ swap;
        pending_d     = (pending_q || last_wr) && !swap;
        frame_valid_d = frame_valid_q || swap;
        overrun_d     = overrun_q || (wr_en && (wr_idx == '0) && pending_q);
        edges_d       = '0;
        if (frame_valid_d) begin
            // Bypass covers a read of the entry being written on the swap edge.
            edges_d = (wr_en && (wr_addr == rd_addr)) ? wr_data : mem_q[rd_addr];
        end
    end

    always_ff @(posedge CLK) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            idx_q         <= '0;
            sel_q         <= 1'b0;
            pending_q     <= 1'b0;
            frame_valid_q <= 1'b0;
            commit_q      <= 1'b0;
            overrun_q     <= 1'b0;
            edges_q       <= '0;
        end else begin
            idx_q         <= idx_d;
            sel_q         <= sel_d;
            pending_q     <= pending_d;
            frame_valid_q <= frame_valid_d;
            commit_q      <= swap;
            overrun_q     <= overrun_d;
            edges_q       <= edges_d;
        end
    end

    assign RISE_OUT    = edges_q.rise;
    assign FALL_OUT    = edges_q.fall;
    assign FRAME_VALID = frame_valid_q;
    assign COMMIT      = commit_q;
    assign OVERRUN     = overrun_q;

endmodule

// File: tb/tb_pulse_edge_buffer.sv
// tb/tb_pulse_edge_buffer.sv - self-checking bench for pulse_edge_buffer
module tb_pulse_edge_buffer;

    localparam int DEPTH = 249;
    localparam int AW    = $clog2(DEPTH);

    logic          CLK = 1'b0;
    logic          RST_N;
    logic          UPDATE;
    logic          DIN_VALID;
    logic [15:0]   INTENSITY_IN;
    logic [7:0]    PHASE_IN;
    logic [AW-1:0] RD_ADDR;
    logic [8:0]    RISE_OUT;
    logic [8:0]    FALL_OUT;
    logic          FRAME_VALID;
    logic          COMMIT;
    logic          OVERRUN;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [15:0] inten;
        logic [7:0]  phase;
        int          rise;
        int          fall;
    } vec_t;

    vec_t        vecs [6];
    logic [15:0] rnd_i [DEPTH];
    logic [7:0]  rnd_p [DEPTH];

    pulse_edge_buffer #(.DEPTH(DEPTH)) dut (
        .CLK          (CLK),
        .RST_N        (RST_N),
        .UPDATE       (UPDATE),
        .DIN_VALID    (DIN_VALID),
        .INTENSITY_IN (INTENSITY_IN),
        .PHASE_IN     (PHASE_IN),
        .RD_ADDR      (RD_ADDR),
        .RISE_OUT     (RISE_OUT),
        .FALL_OUT     (FALL_OUT),
        .FRAME_VALID  (FRAME_VALID),
        .COMMIT       (COMMIT),
        .OVERRUN      (OVERRUN)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    function automatic int model_rise(input int inten, input int phase);
        int w;
        w = inten / 256;
        return (2 * phase - w / 2 + 512) % 512;
    endfunction

    function automatic int model_fall(input int inten, input int phase);
        return (model_rise(inten, phase) + inten / 256) % 512;
    endfunction

    task automatic send_beat(input logic [15:0] inten, input logic [7:0] phase);
        DIN_VALID    = 1'b1;
        INTENSITY_IN = inten;
        PHASE_IN     = phase;
        tick();
        DIN_VALID    = 1'b0;
    endtask

    task automatic send_uniform(input logic [15:0] inten, input logic [7:0] phase);
        for (int k = 0; k < DEPTH; k++) send_beat(inten, phase);
    endtask

    task automatic send_random(input bit gaps);
        for (int k = 0; k < DEPTH; k++) begin
            if (gaps) repeat ($urandom_range(0, 2)) tick();
            send_beat(rnd_i[k], rnd_p[k]);
        end
    endtask

    task automatic do_update(input logic exp_commit);
        UPDATE = 1'b1;
        tick();
        UPDATE = 1'b0;
        check("commit", COMMIT, exp_commit);
        tick();
        check("commit_one_cycle", COMMIT, 0);
    endtask

    task automatic read_check(input int a, input int er, input int ef);
        RD_ADDR = AW'(a);
        tick();
        check($sformatf("rise[%0d]", a), RISE_OUT, er);
        check($sformatf("fall[%0d]", a), FALL_OUT, ef);
    endtask

    initial begin
        vecs[0] = '{16'd65025, 8'd0,   385, 127};
        vecs[1] = '{16'd65025, 8'd128, 129, 383};
        vecs[2] = '{16'd0,     8'd77,  154, 154};
        vecs[3] = '{16'd256,   8'd255, 510, 511};
        vecs[4] = '{16'd32768, 8'd10,  468, 84};
        vecs[5] = '{16'd65535, 8'd0,   385, 128};
        for (int k = 0; k < DEPTH; k++) begin
            rnd_i[k] = 16'($urandom_range(0, 65535));
            rnd_p[k] = 8'($urandom_range(0, 255));
        end

        RST_N = 1'b0; UPDATE = 1'b0; DIN_VALID = 1'b0;
        INTENSITY_IN = '0; PHASE_IN = '0; RD_ADDR = '0;
        repeat (3) tick();
        check("reset_frame_valid", FRAME_VALID, 0);
        check("reset_commit", COMMIT, 0);
        check("reset_overrun", OVERRUN, 0);
        check("reset_rise", RISE_OUT, 0);
        RST_N = 1'b1;
        tick();

        read_check(5, 0, 0);
        check("idle_frame_valid", FRAME_VALID, 0);
        do_update(1'b0);
        check("idle_frame_valid_after_update", FRAME_VALID, 0);

        for (int v = 0; v < 6; v++) begin
            send_uniform(vecs[v].inten, vecs[v].phase);
            tick();
            do_update(1'b1);
            check("frame_valid", FRAME_VALID, 1);
            for (int a = 0; a < DEPTH; a++) read_check(a, vecs[v].rise, vecs[v].fall);
        end

        // Completed frame waits for UPDATE; old front stays visible.
        send_uniform(16'd0, 8'd77);
        repeat (2) tick();
        read_check(0, 385, 128);
        read_check(DEPTH - 1, 385, 128);
        do_update(1'b1);
        read_check(0, 154, 154);

        // UPDATE coincides with the last write.
        send_uniform(16'd65025, 8'd128);
        UPDATE = 1'b1;
        tick();
        UPDATE = 1'b0;
        check("same_cycle_commit", COMMIT, 1);
        tick();
        check("same_cycle_commit_one_cycle", COMMIT, 0);
        read_check(0, 129, 383);
        read_check(DEPTH - 1, 129, 383);
        do_update(1'b0);

        // Second frame while first still pending.
        check("overrun_before", OVERRUN, 0);
        send_uniform(16'd65025, 8'd0);
        tick();
        check("overrun_first_frame", OVERRUN, 0);
        send_uniform(16'd256, 8'd255);
        tick();
        check("overrun_set", OVERRUN, 1);
        read_check(0, 129, 383);
        do_update(1'b1);
        read_check(0, 510, 511);
        read_check(DEPTH - 1, 510, 511);
        repeat (10) tick();
        check("overrun_sticky", OVERRUN, 1);

        // Reset mid-frame discards the partial frame.
        for (int k = 0; k < 100; k++) send_beat(rnd_i[k], rnd_p[k]);
        RST_N = 1'b0;
        #1;
        check("midreset_frame_valid", FRAME_VALID, 0);
        check("midreset_overrun", OVERRUN, 0);
        check("midreset_rise", RISE_OUT, 0);
        tick();
        RST_N = 1'b1;
        tick();
        send_random(1'b0);
        tick();
        do_update(1'b1);
        for (int a = 0; a < DEPTH; a++)
            read_check(a, model_rise(rnd_i[a], rnd_p[a]), model_fall(rnd_i[a], rnd_p[a]));

        send_uniform(16'd0, 8'd0);
        tick();
        do_update(1'b1);
        read_check(7, 0, 0);
        send_random(1'b1);
        tick();
        do_update(1'b1);
        for (int a = 0; a < DEPTH; a++)
            read_check(a, model_rise(rnd_i[a], rnd_p[a]), model_fall(rnd_i[a], rnd_p[a]));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
